// File: rtl/fifo_rr_drain_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
package fifo_sched_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} sched_state_t;

    localparam int MAX_SRC = 32;

    // First set request bit searching upward from last+1, wrapping modulo n.
    function automatic int rr_pick(input logic [MAX_SRC-1:0] req, input int last, input int n);
        int pick;
        int idx;
        pick = last;
        for (int k = n; k >= 1; k--) begin
            idx  = (last + k) % n;
            pick = req[idx] ? idx : pick;
        end
        return pick;
    endfunction

    function automatic logic [1:0] skid_ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : (p + 2'd1);
    endfunction

endpackage

// File: rtl/fifo_rr_drain_sched_if.sv
// Bundle of FIFO-bank, configuration and output-stream signals around the scheduler.
interface fifo_rr_drain_sched_if #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 128
);
    localparam int SW = $clog2(N_SRC);

    logic                        cfg_enable;
    logic [N_SRC-1:0]            cfg_mask;
    logic [N_SRC-1:0]            src_mty;
    logic [N_SRC-1:0]            src_almost_mty;
    logic [N_SRC*DATA_WIDTH-1:0] src_q;
    logic [N_SRC-1:0]            src_rd;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_data;
    logic [SW-1:0]               out_src;
    logic                        busy;

    modport master (
        input  cfg_enable, cfg_mask, src_mty, src_almost_mty, src_q, out_ready,
        output src_rd, out_valid, out_data, out_src, busy
    );

    modport slave (
        output cfg_enable, cfg_mask, src_mty, src_almost_mty, src_q, out_ready,
        input  src_rd, out_valid, out_data, out_src, busy
    );

endinterface

// File: rtl/fifo_rr_drain_sched_rr_arbiter.sv
// Combinational round-robin pick among requesting sources.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [MAX_SRC-1:0] req_ext_s;

    // Widen the request vector for the shared pick function.
    always_comb begin
        req_ext_s        = '0;
        req_ext_s[N-1:0] = req_i;
        gnt_idx_o        = IW'(rr_pick(req_ext_s, int'(32'(last_i)), N));
        gnt_vld_o        = |req_i;
    end

endmodule

// File: rtl/fifo_rr_drain_sched.sv
// Drains N_SRC upstream FIFOs round-robin into one valid/ready stream through a 3-entry skid.
module fifo_rr_drain_sched
    import fifo_sched_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 128,
    parameter int BURST_MAX  = 4
) (
    input logic                   CLK,
    input logic                   ARST_N,
    fifo_rr_drain_sched_if.master bus
);

    localparam int SW = $clog2(N_SRC);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef struct packed {
        logic [SW-1:0]         src;
        logic [DATA_WIDTH-1:0] data;
    } skid_ent_t;

    sched_state_t     state_q, state_d;
    logic [SW-1:0]    grant_q, grant_d;
    logic [SW-1:0]    last_q, last_d;
    logic [BW-1:0]    burst_q, burst_d;
    skid_ent_t        skid_q [3];
    logic [1:0]       wr_ptr_q, rd_ptr_q, occ_q;
    logic             infl_q;
    logic [SW-1:0]    infl_src_q;

    logic [N_SRC-1:0] elig_s;
    logic [SW-1:0]    gnt_idx_s;
    logic             gnt_vld_s;
    logic             cap_ok_s, rd_en_s, done_s, push_s, pop_s;
    logic [DATA_WIDTH-1:0] src_word_s;

    assign elig_s = ~bus.src_mty & ~bus.cfg_mask & {N_SRC{bus.cfg_enable}};

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req_i     (elig_s),
        .last_i    (last_q),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (gnt_vld_s)
    );

    // A pop in the same cycle is deliberately not credited, keeping the skid from overflowing.
    assign cap_ok_s = ({1'b0, occ_q} + {2'b00, infl_q}) <= 3'd1;

    // Scheduler next-state: grant selection in IDLE, read issue and grant termination in BURST.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        rd_en_s = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld_s) begin
                    grant_d = gnt_idx_s;
                    state_d = BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                rd_en_s = cap_ok_s & ~bus.src_mty[grant_q] & bus.cfg_enable;
                done_s  = (rd_en_s & ((burst_q == BW'(BURST_MAX - 1)) | bus.src_almost_mty[grant_q]))
                        | bus.src_mty[grant_q] | ~bus.cfg_enable | bus.cfg_mask[grant_q];
                if (done_s) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    burst_d = '0;
                end else if (rd_en_s) begin
                    burst_d = burst_q + BW'(1);
                end else begin
                    burst_d = burst_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state registers; last grant starts at N_SRC-1 so source 0 wins first.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= SW'(N_SRC - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    assign bus.src_rd = rd_en_s ? (N_SRC'(1) << grant_q) : '0;

    assign push_s     = infl_q;
    assign pop_s      = (occ_q != 2'd0) & bus.out_ready;
    assign src_word_s = bus.src_q[infl_src_q*DATA_WIDTH +: DATA_WIDTH];

    // Skid buffer: captures read data one cycle after rd, drains on valid&ready.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            for (int i = 0; i < 3; i++) begin
                skid_q[i] <= '0;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            occ_q      <= 2'd0;
            infl_q     <= 1'b0;
            infl_src_q <= '0;
        end else begin
            infl_q     <= rd_en_s;
            infl_src_q <= grant_q;
            if (push_s) begin
                skid_q[wr_ptr_q] <= '{src: infl_src_q, data: src_word_s};
                wr_ptr_q         <= skid_ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= skid_ptr_inc(rd_ptr_q);
            end
            occ_q <= occ_q + 2'(push_s) - 2'(pop_s);
        end
    end

    // Output view of the skid head; zero while empty.
    always_comb begin
        bus.out_valid = (occ_q != 2'd0);
        if (occ_q != 2'd0) begin
            bus.out_data = skid_q[rd_ptr_q].data;
            bus.out_src  = skid_q[rd_ptr_q].src;
        end else begin
            bus.out_data = '0;
            bus.out_src  = '0;
        end
        bus.busy = (state_q != IDLE) | (occ_q != 2'd0) | infl_q;
    end

endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// Directed bench: FIFO-bank model with one-cycle read latency and lagging empty flag.
module tb_fifo_rr_drain_sched;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int BM = 4;

    logic CLK    = 1'b0;
    logic ARST_N = 1'b0;
    always #5 CLK = ~CLK;

    fifo_rr_drain_sched_if #(.N_SRC(N), .DATA_WIDTH(DW)) bus ();

    fifo_rr_drain_sched #(.N_SRC(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .CLK    (CLK),
        .ARST_N (ARST_N),
        .bus    (bus)
    );

    function automatic logic [DW-1:0] word(int s, int k);
        return {32'hD0D0_0000 + 32'(s), 32'(k), 64'h0123_4567_89AB_CDEF ^ {32'(s), 32'(k)}};
    endfunction

    // Upstream FIFO model: empty flag lags one cycle, almost-empty is exact.
    int unsigned    cnt_q [N];
    int unsigned    ptr_q [N];
    logic [DW-1:0]  q_q [N]   = '{default: '0};
    logic [N-1:0]   mty_lag_q = '1;
    int             ld_cnt [N];
    logic           ld_go  = 1'b0;
    int             bad_rd = 0;

    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            mty_lag_q[i] <= (cnt_q[i] == 0);
            if (ld_go) begin
                cnt_q[i] <= ld_cnt[i];
                ptr_q[i] <= 0;
            end else if (bus.src_rd[i]) begin
                if (cnt_q[i] == 0) begin
                    bad_rd <= bad_rd + 1;
                end else begin
                    q_q[i]   <= word(i, int'(ptr_q[i]));
                    ptr_q[i] <= ptr_q[i] + 1;
                    cnt_q[i] <= cnt_q[i] - 1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.src_mty[i]        = mty_lag_q[i];
            bus.src_almost_mty[i] = (cnt_q[i] == 1);
            bus.src_q[i*DW +: DW] = q_q[i];
        end
    end

    // Monitors: record every rd strobe and every accepted output word.
    int            rd_src_q [$];
    int            rd_cyc_q [$];
    logic [DW-1:0] od_q [$];
    int            os_q [$];
    int            cyc   = 0;
    int            multi = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (ARST_N) begin
            if ($countones(bus.src_rd) > 1) multi <= multi + 1;
            for (int i = 0; i < N; i++) begin
                if (bus.src_rd[i]) begin
                    rd_src_q.push_back(i);
                    rd_cyc_q.push_back(cyc);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                od_q.push_back(bus.out_data);
                os_q.push_back(int'(bus.out_src));
            end
        end
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_outs(int target, int limit, string tag);
        int n = 0;
        while (od_q.size() < target && n < limit) begin
            step();
            n++;
        end
        chk(tag, DW'(od_q.size() >= target), DW'(1'b1));
    endtask

    task automatic wait_idle(int limit, string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        chk(tag, DW'(bus.busy), DW'(1'b0));
    endtask

    task automatic reset_and_load(int c0, int c1, int c2, int c3);
        ARST_N         = 1'b0;
        bus.cfg_enable = 1'b0;
        ld_cnt[0] = c0; ld_cnt[1] = c1; ld_cnt[2] = c2; ld_cnt[3] = c3;
        ld_go = 1'b1;
        step();
        ld_go = 1'b0;
        step();
        ARST_N         = 1'b1;
        bus.cfg_enable = 1'b1;
    endtask

    initial begin : main
        int rb, ob, bad0, mul0, k, found;
        int exp_off [8] = '{0, 1, 3, 4, 6, 7, 9, 10};
        int mask_ord [3] = '{0, 2, 3};

        bus.cfg_enable = 1'b0;
        bus.cfg_mask   = 4'b0000;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < N; i++) ld_cnt[i] = 0;
        step(2);

        // Reset state
        chk("rst_src_rd",    DW'(bus.src_rd),    DW'(4'b0000));
        chk("rst_out_valid", DW'(bus.out_valid), DW'(1'b0));
        chk("rst_out_data",  bus.out_data,       DW'(1'b0));
        chk("rst_out_src",   DW'(bus.out_src),   DW'(2'd0));
        chk("rst_busy",      DW'(bus.busy),      DW'(1'b0));

        // Four sources with 8 words each: grants 0,1,2,3,0,1,2,3 of 4 reads
        reset_and_load(8, 8, 8, 8);
        rb = rd_src_q.size(); ob = od_q.size(); bad0 = bad_rd; mul0 = multi;
        wait_outs(ob + 32, 400, "rr_outs_timeout");
        wait_idle(40, "rr_idle_timeout");
        chk("rr_rd_count", DW'(rd_src_q.size() - rb), DW'(32));
        for (int i = 0; i < 32; i++) begin
            k = (i / 4) % 4;
            chk($sformatf("rr_rd_src[%0d]", i), DW'(rd_src_q[rb + i]), DW'(k));
            chk($sformatf("rr_out_src[%0d]", i), DW'(os_q[ob + i]), DW'(k));
            chk($sformatf("rr_out_data[%0d]", i), od_q[ob + i], word(k, (i / 16) * 4 + i % 4));
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_rd_offset[%0d]", i), DW'(rd_cyc_q[rb + i] - rd_cyc_q[rb]), DW'(exp_off[i]));
        end
        chk("rr_no_empty_read", DW'(bad_rd - bad0), DW'(0));
        chk("rr_onehot_rd", DW'(multi - mul0), DW'(0));

        // Reset asserted mid-burst of src 2
        reset_and_load(8, 8, 8, 8);
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            step();
            if (bus.src_rd[2]) found = 1;
        end
        chk("mid_rst_found_src2_rd", DW'(found), DW'(1));
        #1 ARST_N = 1'b0;
        #1;
        chk("mid_rst_src_rd",    DW'(bus.src_rd),    DW'(4'b0000));
        chk("mid_rst_out_valid", DW'(bus.out_valid), DW'(1'b0));
        chk("mid_rst_busy",      DW'(bus.busy),      DW'(1'b0));
        step(2);
        ARST_N = 1'b1;
        rb = rd_src_q.size();
        for (int i = 0; i < 20 && rd_src_q.size() == rb; i++) step();
        chk("mid_rst_first_rd_seen", DW'(rd_src_q.size() > rb), DW'(1'b1));
        if (rd_src_q.size() > rb) chk("mid_rst_first_grant", DW'(rd_src_q[rb]), DW'(0));

        // Backpressure: out_ready low for 12 cycles during a burst of src 0
        bus.out_ready = 1'b0;
        reset_and_load(8, 0, 0, 0);
        rb = rd_src_q.size(); ob = od_q.size(); bad0 = bad_rd;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid) begin
                chk($sformatf("bp_hold_data[%0d]", i), bus.out_data, word(0, 0));
                chk($sformatf("bp_hold_src[%0d]", i), DW'(bus.out_src), DW'(2'd0));
            end
        end
        chk("bp_rd_count",  DW'(rd_src_q.size() - rb), DW'(2));
        chk("bp_out_valid", DW'(bus.out_valid), DW'(1'b1));
        chk("bp_no_accept", DW'(od_q.size() - ob), DW'(0));
        bus.out_ready = 1'b1;
        wait_outs(ob + 8, 200, "bp_outs_timeout");
        wait_idle(40, "bp_idle_timeout");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_out_data[%0d]", i), od_q[ob + i], word(0, i));
        end
        chk("bp_total_outs", DW'(od_q.size() - ob), DW'(8));
        chk("bp_no_empty_read", DW'(bad_rd - bad0), DW'(0));

        // Src 2 holds one word: exactly one rd, no second read on the stale empty flag
        reset_and_load(0, 0, 1, 0);
        rb = rd_src_q.size(); ob = od_q.size(); bad0 = bad_rd;
        step(15);
        chk("am_rd_count", DW'(rd_src_q.size() - rb), DW'(1));
        if (rd_src_q.size() > rb) chk("am_rd_src", DW'(rd_src_q[rb]), DW'(2));
        chk("am_out_count", DW'(od_q.size() - ob), DW'(1));
        if (od_q.size() > ob) chk("am_out_data", od_q[ob], word(2, 0));
        chk("am_no_empty_read", DW'(bad_rd - bad0), DW'(0));
        chk("am_busy", DW'(bus.busy), DW'(1'b0));

        // Mask src 1: order 0,2,3,0,2,3
        bus.cfg_mask = 4'b0010;
        reset_and_load(8, 8, 8, 8);
        rb = rd_src_q.size(); ob = od_q.size();
        wait_outs(ob + 24, 400, "mask_outs_timeout");
        wait_idle(40, "mask_idle_timeout");
        step(10);
        chk("mask_rd_count", DW'(rd_src_q.size() - rb), DW'(24));
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("mask_rd_src[%0d]", i), DW'(rd_src_q[rb + i]), DW'(mask_ord[(i / 4) % 3]));
        end
        bus.cfg_mask = 4'b0000;

        // cfg_enable dropped the cycle after the first rd of src 3
        reset_and_load(0, 0, 0, 3);
        rb = rd_src_q.size(); ob = od_q.size();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (bus.src_rd != 4'b0000) found = 1;
        end
        chk("en_found_rd", DW'(found), DW'(1));
        step();
        bus.cfg_enable = 1'b0;
        chk("en_busy_t1", DW'(bus.busy), DW'(1'b1));
        step();
        chk("en_out_valid_t2", DW'(bus.out_valid), DW'(1'b1));
        chk("en_out_data_t2",  bus.out_data, word(3, 0));
        chk("en_busy_t2", DW'(bus.busy), DW'(1'b1));
        step();
        chk("en_busy_t3", DW'(bus.busy), DW'(1'b0));
        step(5);
        chk("en_rd_count",  DW'(rd_src_q.size() - rb), DW'(1));
        chk("en_out_count", DW'(od_q.size() - ob), DW'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
